// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the shared 16-bit execute ALU.
// Produces the low 16 bits of mcand*mplier using only the ALU's ADD and SLL ops.
module alu_mul_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] mcand,
   input  logic [15:0] mplier,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic        mul_ov,
   output logic        alu_own,
   output logic [3:0]  alu_op,
   output logic [15:0] alu_src0,
   output logic [15:0] alu_src1,
   output logic [15:0] alu_imm,
   output logic [2:0]  alu_flag_reg,
   input  logic [15:0] alu_result,
   input  logic [2:0]  alu_flags,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADD   = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0101;

   state_t      state_q, state_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] mc_q, mc_d;
   logic [15:0] mp_q, mp_d;
   logic        ov_q, ov_d;

   // Only the V flag matters to the sequencer; N and Z are deliberately ignored.
   logic unused_flags;
   assign unused_flags = alu_flags[2] ^ alu_flags[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mc_q    <= '0;
         mp_q    <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mc_q    <= mc_d;
         mp_q    <= mp_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mc_d     = mc_q;
      mp_d     = mp_q;
      ov_d     = ov_q;
      busy     = 1'b0;
      done     = 1'b0;
      alu_own  = 1'b0;
      alu_op   = 4'b0000;
      alu_src0 = '0;
      alu_src1 = '0;
      alu_imm  = '0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = '0;
               mc_d  = mcand;
               mp_d  = mplier;
               ov_d  = 1'b0;
               if (mplier == 16'h0000) state_d = S_DONE;
               else if (mplier[0])     state_d = S_ADD;
               else                    state_d = S_SHIFT;
            end
         end
         S_ADD: begin
            busy     = 1'b1;
            alu_own  = 1'b1;
            alu_op   = OP_ADD;
            alu_src0 = acc_q;
            alu_src1 = mc_q;
            acc_d    = alu_result;
            ov_d     = ov_q | alu_flags[1];
            state_d  = (mp_q[15:1] == 15'd0) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            busy     = 1'b1;
            alu_own  = 1'b1;
            alu_op   = OP_SLL;
            alu_src0 = mc_q;
            alu_imm  = 16'h0001;
            mc_d     = alu_result;
            mp_d     = {1'b0, mp_q[15:1]};
            // mp_q[1] is the LSB of the shifted multiplier; it is never all-zero here.
            state_d  = mp_q[1] ? S_ADD : S_SHIFT;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign product      = acc_q;
   assign mul_ov       = ov_q;
   assign alu_flag_reg = 3'b000;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU; a monitor pops
// expected {done cycle, mul_ov, product} entries whenever done is seen.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] mcand = '0;
   logic [15:0] mplier = '0;
   logic        busy, done, mul_ov, alu_own;
   logic [15:0] product, alu_src0, alu_src1, alu_imm, alu_result;
   logic [3:0]  alu_op;
   logic [2:0]  alu_flag_reg, alu_flags;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [48:0] exp_q[$];

   alu_mul_seq dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product), .mul_ov(mul_ov),
      .alu_own(alu_own), .alu_op(alu_op), .alu_src0(alu_src0),
      .alu_src1(alu_src1), .alu_imm(alu_imm), .alu_flag_reg(alu_flag_reg),
      .alu_result(alu_result), .alu_flags(alu_flags), .dbg_state(dbg_state)
   );

   // Clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural execute ALU: ADD with signed overflow, SLL by imm[3:0]
   logic [15:0] alu_r;
   always_comb begin
      alu_r     = '0;
      alu_flags = '0;
      case (alu_op)
         4'b0000: begin
            alu_r        = alu_src0 + alu_src1;
            alu_flags[1] = (alu_src0[15] == alu_src1[15]) && (alu_r[15] != alu_src0[15]);
         end
         4'b0101: alu_r = alu_src0 << alu_imm[3:0];
         default: alu_r = '0;
      endcase
      alu_flags[2] = alu_r[15];
      alu_flags[0] = (alu_r == 16'h0000);
      alu_result   = alu_r;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            logic [48:0] e;
            e = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e[48:17]));
            check("product", 64'(product), 64'(e[15:0]));
            check("mul_ov", 64'(mul_ov), 64'(e[16]));
         end
      end
   end

   // Driver tasks
   task automatic wait_idle();
      for (int i = 0; i < 200 && dbg_state != 2'd0; i++) @(negedge clk);
      if (dbg_state != 2'd0) check("idle_timeout", 64'(dbg_state), 64'd0);
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ep,
                        input logic eov, input int lat, input bit push);
      wait_idle();
      mcand  = a;
      mplier = b;
      start  = 1'b1;
      if (push) exp_q.push_back({32'(cyc + lat), eov, ep});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end expected end by 200000");
      $fatal(1, "watchdog");
   end

   logic        own_exp [1:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [1:0]  st_exp  [1:6] = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0};

   initial begin
      int n;
      repeat (2) @(negedge clk);
      check("rst_ctrl", 64'({busy, done, alu_own, mul_ov}), 64'd0);
      check("rst_product", 64'(product), 64'd0);
      check("rst_alu", 64'({alu_op, alu_src0, alu_src1, alu_imm, alu_flag_reg}), 64'd0);
      check("rst_state", 64'(dbg_state), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 3 x 5: cycle-by-cycle state and ALU drive
      issue(16'd3, 16'd5, 16'd15, 1'b0, 5, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         check("own_3x5", 64'(alu_own), 64'(own_exp[k]));
         check("state_3x5", 64'(dbg_state), 64'(st_exp[k]));
         if (k == 3) check("shift_src0", 64'({alu_op, alu_src0, alu_imm}), {40'd0, 4'b0101, 16'd6, 16'd1});
         if (k == 4) check("add_srcs", 64'({alu_op, alu_src0, alu_src1}), {28'd0, 4'b0000, 16'd3, 16'd12});
         @(negedge clk);
      end
      drain();

      // mplier = 0: immediate done, ALU untouched
      issue(16'h1234, 16'h0000, 16'h0000, 1'b0, 1, 1'b1);
      for (int k = 1; k <= 2; k++) begin
         check("zero_own", 64'({alu_own, alu_op}), 64'd0);
         @(negedge clk);
      end
      drain();

      // 0x00FF x 0x0101 with SHIFT drive check
      issue(16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 11, 1'b1);
      @(negedge clk);
      check("ff_shift_drive", 64'({alu_op, alu_imm, alu_src1}), {28'd0, 4'b0101, 16'h0001, 16'h0000});
      drain();

      // Overflow: 0x3000 x 3, mul_ov held after done
      issue(16'h3000, 16'h0003, 16'h9000, 1'b1, 4, 1'b1);
      drain();
      repeat (2) @(negedge clk);
      check("ov_hold", 64'({mul_ov, product}), {47'd0, 1'b1, 16'h9000});

      // Boundary vectors: worst-case latency and truncation of mc
      issue(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 32, 1'b1);
      drain();
      issue(16'h0002, 16'h8000, 16'h0000, 1'b0, 17, 1'b1);
      drain();
      issue(16'h0005, 16'h0003, 16'h000F, 1'b0, 4, 1'b1);
      drain();

      // start pulsed mid-run is ignored
      issue(16'd3, 16'd5, 16'd15, 1'b0, 5, 1'b1);
      start  = 1'b1;
      mcand  = 16'hFFFF;
      mplier = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      drain();

      // start held high: second run accepted in the IDLE after DONE
      wait_idle();
      n = cyc;
      mcand  = 16'd3;
      mplier = 16'd5;
      start  = 1'b1;
      exp_q.push_back({32'(n + 5), 1'b0, 16'd15});
      exp_q.push_back({32'(n + 11), 1'b0, 16'd15});
      repeat (8) @(negedge clk);
      start = 1'b0;
      drain();

      // Reset mid-run aborts, then 7 x 6
      issue(16'd3, 16'd5, 16'd15, 1'b0, 5, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ctrl", 64'({busy, done, alu_own}), 64'd0);
      check("abort_product", 64'(product), 64'd0);
      rst = 1'b0;
      issue(16'd7, 16'd6, 16'd42, 1'b0, 5, 1'b1);
      drain();

      while (exp_q.size() != 0) begin
         logic [48:0] e;
         e = exp_q.pop_front();
         check("missing_done", 64'd0, 64'(e[48:17]));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
